// File: rtl/midi_router_pkg.sv
// Shared definitions for the reset sequencer: state encodings, counter width
// and a saturating counter helper.
package midi_router_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] ST_HOLD_ENC     = 2'd0;
    localparam logic [1:0] ST_RELEASE_ENC  = 2'd1;
    localparam logic [1:0] ST_WAIT_RDY_ENC = 2'd2;
    localparam logic [1:0] ST_RUN_ENC      = 2'd3;

    typedef enum logic [1:0] {
        ST_HOLD     = ST_HOLD_ENC,
        ST_RELEASE  = ST_RELEASE_ENC,
        ST_WAIT_RDY = ST_WAIT_RDY_ENC,
        ST_RUN      = ST_RUN_ENC
    } seq_state_t;

    // The counter sticks at its maximum instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/prio_arbiter.sv
// Lowest-index-first combinational arbiter: the grant is a one-hot copy of the
// lowest set request bit, or all zero when nothing is requested.
module prio_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant
);

    // Two's-complement trick isolates the lowest set bit of the request vector.
    assign o_grant = i_req & (~i_req + N'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all downstream domains in reset, then releases them
// one at a time in index order, waiting for each domain's ready before moving
// on. Soft-reset requests seen in RUN restart the whole sequence.
// Optional feature: define RESET_SEQUENCER_TIMEOUT_EN to give up on a silent
// domain after READY_TIMEOUT cycles, flag timeout_err and carry on.
module reset_sequencer
    import midi_router_pkg::*;
#(
    parameter int NUM_DOMAINS   = 4,
    parameter int NUM_REQ       = 2,
    parameter int HOLD_CYCLES   = 16,
    parameter int READY_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     soft_req,
    input  logic [NUM_DOMAINS-1:0] domain_ready,
    output logic [NUM_DOMAINS-1:0] nreset_dom,
    output logic [NUM_REQ-1:0]     soft_ack,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_badHoldCycles
        $error("reset_sequencer: HOLD_CYCLES must be within 1..255");
    end
    if (READY_TIMEOUT < 1 || READY_TIMEOUT > 255) begin : g_badReadyTimeout
        $error("reset_sequencer: READY_TIMEOUT must be within 1..255");
    end

    seq_state_t             r_state, w_nextState;
    logic [IDX_W-1:0]       r_idx, w_nextIdx;
    logic [CNT_W-1:0]       r_cnt, w_nextCnt;
    logic [NUM_DOMAINS-1:0] r_nreset, w_nextNreset;
    logic [NUM_REQ-1:0]     r_ack, w_nextAck;
    logic [NUM_REQ-1:0]     w_grant;
    logic                   w_advance;

`ifdef RESET_SEQUENCER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(READY_TIMEOUT - 1);
    logic r_terr, w_nextTerr;
`endif

    prio_arbiter #(
        .N(NUM_REQ)
    ) u_arbiter (
        .i_req  (soft_req),
        .o_grant(w_grant)
    );

    // State register; outputs are registered here too so they never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_HOLD;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_nreset <= '0;
            r_ack    <= '0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
            r_terr   <= 1'b0;
`endif
        end else begin
            r_state  <= w_nextState;
            r_idx    <= w_nextIdx;
            r_cnt    <= w_nextCnt;
            r_nreset <= w_nextNreset;
            r_ack    <= w_nextAck;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
            r_terr   <= w_nextTerr;
`endif
        end
    end

    // Next-state logic: hold countdown, per-domain release and ready wait, soft restart.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        w_nextCnt   = r_cnt;
        w_advance   = 1'b0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
        w_nextTerr  = r_terr;
`endif
        case (r_state)
            ST_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_nextState = ST_RELEASE;
                    w_nextIdx   = '0;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = satInc(r_cnt);
                end
            end
            ST_RELEASE: begin
                w_nextState = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                w_advance = domain_ready[r_idx];
`ifdef RESET_SEQUENCER_TIMEOUT_EN
                if (!domain_ready[r_idx]) begin
                    if (r_cnt == TIMEOUT_LAST) begin
                        w_advance  = 1'b1;
                        w_nextTerr = 1'b1;
                    end else begin
                        w_nextCnt = satInc(r_cnt);
                    end
                end
`endif
                if (w_advance) begin
                    w_nextCnt = '0;
                    if (r_idx == LAST_IDX) begin
                        w_nextState = ST_RUN;
                    end else begin
                        w_nextState = ST_RELEASE;
                        w_nextIdx   = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (|soft_req) begin
                    w_nextState = ST_HOLD;
                    w_nextIdx   = '0;
                    w_nextCnt   = '0;
                end
            end
            default: begin
                w_nextState = ST_HOLD;
                w_nextIdx   = '0;
                w_nextCnt   = '0;
            end
        endcase
    end

    // Output logic: domain resets follow the state being entered, so a domain's
    // nreset rises on the same edge that moves the FSM into RELEASE for it.
    always_comb begin
        w_nextNreset = '0;
        w_nextAck    = '0;
        case (w_nextState)
            ST_RELEASE, ST_WAIT_RDY: begin
                for (int i = 0; i < NUM_DOMAINS; i++) begin
                    w_nextNreset[i] = (i <= int'(w_nextIdx));
                end
            end
            ST_RUN:  w_nextNreset = '1;
            default: w_nextNreset = '0;
        endcase
        if (r_state == ST_RUN) begin
            w_nextAck = w_grant;
        end
        busy = (r_state != ST_RUN);
    end

    assign nreset_dom = r_nreset;
    assign soft_ack   = r_ack;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    assign timeout_err = r_terr;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
